load_store_unit: RTL and testbench

- Sits directly downstream of the instruction controller in the execute/memory stage.
- Consumes the controller's rd_en, wr_en and mem_acc_mode, plus the ALU-computed address and register-file store data.
- Runs one valid/ready transaction per load/store on a word-wide data bus, doing byte-lane alignment, byte enables, load sign/zero extension, misalignment checking and bus timeout.
- Stalls the core until the access completes.

---
 rtl/load_store_unit.sv | 159 +++++++++++++++
 tb/tb_load_store_unit.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// Load/store unit: turns a controller load/store request into one valid/ready word-bus
// transaction. It aligns byte lanes, extends load data, flags bad requests and aborts stuck accesses.
module load_store_unit #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rd_en,
  input  logic        wr_en,
  input  logic [2:0]  mem_acc_mode,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        stall,
  output logic        lsu_err,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wdata,
  input  logic        bus_ready,
  input  logic [31:0] bus_rdata
);

  localparam logic [1:0] IDLE = 2'b00;
  localparam logic [1:0] REQ  = 2'b01;
  localparam logic [1:0] DONE = 2'b10;

  localparam logic [2:0] MODE_B  = 3'b000;
  localparam logic [2:0] MODE_H  = 3'b001;
  localparam logic [2:0] MODE_W  = 3'b010;
  localparam logic [2:0] MODE_BU = 3'b011;
  localparam logic [2:0] MODE_HU = 3'b100;

  localparam logic [7:0] LAST_CNT = 8'(TIMEOUT - 1);

  logic [1:0]  state;
  logic [2:0]  mode_q;
  logic [1:0]  off_q;
  logic [7:0]  cnt;

  logic        req_any;
  logic        mode_legal;
  logic        misaligned;
  logic        req_ok;
  logic        req_bad;
  logic [3:0]  be_next;
  logic [31:0] wdata_next;
  logic [31:0] lane;
  logic [31:0] load_val;

  // Request qualification: exactly one of rd_en/wr_en, a legal mode for that direction, aligned.
  always_comb begin
    req_any    = rd_en | wr_en;
    mode_legal = 1'b0;
    misaligned = 1'b0;
    case (mem_acc_mode)
      MODE_B, MODE_H, MODE_W: mode_legal = 1'b1;
      MODE_BU, MODE_HU:       mode_legal = rd_en & ~wr_en;
      default:                mode_legal = 1'b0;
    endcase
    case (mem_acc_mode)
      MODE_H, MODE_HU: misaligned = addr[0];
      MODE_W:          misaligned = |addr[1:0];
      default:         misaligned = 1'b0;
    endcase
    req_ok  = (rd_en ^ wr_en) & mode_legal & ~misaligned;
    req_bad = req_any & ~req_ok;
  end

  always_comb begin
    be_next    = 4'b1111;
    wdata_next = wdata;
    case (mem_acc_mode)
      MODE_B, MODE_BU: begin
        be_next    = 4'b0001 << addr[1:0];
        wdata_next = {4{wdata[7:0]}};
      end
      MODE_H, MODE_HU: begin
        be_next    = 4'b0011 << {addr[1], 1'b0};
        wdata_next = {2{wdata[15:0]}};
      end
      default: begin
        be_next    = 4'b1111;
        wdata_next = wdata;
      end
    endcase
  end

  // Shift the addressed lane down to bit 0, then extend according to the latched mode.
  always_comb begin
    lane     = bus_rdata;
    load_val = bus_rdata;
    case (mode_q)
      MODE_B, MODE_BU: lane = bus_rdata >> {off_q, 3'b000};
      MODE_H, MODE_HU: lane = bus_rdata >> {off_q[1], 4'b0000};
      default:         lane = bus_rdata;
    endcase
    case (mode_q)
      MODE_B:  load_val = {{24{lane[7]}}, lane[7:0]};
      MODE_H:  load_val = {{16{lane[15]}}, lane[15:0]};
      MODE_BU: load_val = {24'd0, lane[7:0]};
      MODE_HU: load_val = {16'd0, lane[15:0]};
      default: load_val = lane;
    endcase
  end

  assign bus_req = (state == REQ);
  assign stall   = ((state == IDLE) && req_ok) || (state == REQ);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      mode_q    <= 3'd0;
      off_q     <= 2'd0;
      cnt       <= 8'd0;
      rdata     <= 32'd0;
      lsu_err   <= 1'b0;
      bus_we    <= 1'b0;
      bus_addr  <= 32'd0;
      bus_be    <= 4'd0;
      bus_wdata <= 32'd0;
    end else begin
      lsu_err <= 1'b0;
      case (state)
        IDLE: begin
          if (req_ok) begin
            bus_we    <= wr_en;
            bus_addr  <= {addr[31:2], 2'b00};
            bus_be    <= be_next;
            bus_wdata <= wdata_next;
            mode_q    <= mem_acc_mode;
            off_q     <= addr[1:0];
            cnt       <= 8'd0;
            state     <= REQ;
          end else if (req_bad) begin
            lsu_err <= 1'b1;
          end
        end
        REQ: begin
          // A ready in the last counted cycle still completes the access.
          if (bus_ready) begin
            if (!bus_we) rdata <= load_val;
            state <= DONE;
          end else if (cnt == LAST_CNT) begin
            if (!bus_we) rdata <= 32'd0;
            lsu_err <= 1'b1;
            state   <= DONE;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed test-plan cases plus randomized accesses
// checked against a byte-level reference model.
module tb_load_store_unit;

  localparam int TIMEOUT = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        rd_en, wr_en;
  logic [2:0]  mem_acc_mode;
  logic [31:0] addr, wdata;
  logic [31:0] rdata;
  logic        stall, lsu_err;
  logic        bus_req, bus_we;
  logic [31:0] bus_addr;
  logic [3:0]  bus_be;
  logic [31:0] bus_wdata;
  logic        bus_ready;
  logic [31:0] bus_rdata;

  int n_checks = 0;
  int n_pass   = 0;
  logic [31:0] exp_rdata = 32'd0;

  load_store_unit #(.TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .rd_en(rd_en), .wr_en(wr_en), .mem_acc_mode(mem_acc_mode),
    .addr(addr), .wdata(wdata), .rdata(rdata), .stall(stall), .lsu_err(lsu_err),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_be(bus_be),
    .bus_wdata(bus_wdata), .bus_ready(bus_ready), .bus_rdata(bus_rdata)
  );

  always #5 clk = ~clk;

  // Reference model: access size in bytes, 0 for an unknown mode.
  function automatic int size_of(input logic [2:0] m);
    case (m)
      3'd0, 3'd3: return 1;
      3'd1, 3'd4: return 2;
      3'd2:       return 4;
      default:    return 0;
    endcase
  endfunction

  function automatic bit is_error(input logic rd, input logic wr, input logic [2:0] m, input logic [31:0] a);
    int sz = size_of(m);
    if (rd && wr) return 1;
    if (sz == 0) return 1;
    if (wr && m > 3'd2) return 1;
    if ((a % sz) != 0) return 1;
    return 0;
  endfunction

  function automatic logic [3:0] model_be(input logic [2:0] m, input logic [31:0] a);
    int sz = size_of(m);
    return 4'(((1 << sz) - 1) << (a % 4));
  endfunction

  function automatic logic [31:0] model_wdata(input logic [2:0] m, input logic [31:0] d);
    logic [31:0] r;
    int sz = size_of(m);
    for (int i = 0; i < 4; i++) r[8*i +: 8] = d[8*(i % sz) +: 8];
    return r;
  endfunction

  function automatic logic [31:0] model_load(input logic [2:0] m, input logic [31:0] a, input logic [31:0] w);
    logic [63:0] v = 64'd0;
    int sz  = size_of(m);
    int off = a % 4;
    for (int i = 0; i < sz; i++) v[8*i +: 8] = w[8*(off+i) +: 8];
    if (m < 3'd3 && sz < 4 && v[8*sz-1]) v = v | (~64'd0 << (8*sz));
    return v[31:0];
  endfunction

  // One access from the request cycle through DONE, with the slave inserting 'waits' wait states
  // (waits >= TIMEOUT means the slave never answers).
  task automatic run_access(input logic rd, input logic wr, input logic [2:0] m, input logic [31:0] a,
                            input logic [31:0] wd, input int waits, input logic [31:0] rword, input string name);
    bit err  = is_error(rd, wr, m, a);
    bit tout = (waits >= TIMEOUT);
    int stall_cnt = 0;
    @(posedge clk); #1;
    rd_en = rd; wr_en = wr; mem_acc_mode = m; addr = a; wdata = wd;
    bus_ready = 1'b0; bus_rdata = $urandom;
    @(negedge clk);
    n_checks++;
    if (stall !== ((rd | wr) & ~err)) $display("[TB] FAIL %s req_stall got %b want %b", name, stall, (rd | wr) & ~err);
    else n_pass++;
    if (!(rd | wr) || err) begin
      @(posedge clk); #1;
      rd_en = 1'b0; wr_en = 1'b0;
      @(negedge clk);
      n_checks++;
      if (lsu_err !== ((rd | wr) & err)) $display("[TB] FAIL %s err_pulse got %b want %b", name, lsu_err, (rd | wr) & err);
      else n_pass++;
      n_checks++;
      if (bus_req !== 1'b0 || stall !== 1'b0) $display("[TB] FAIL %s err_nobus got req=%b stall=%b want 0 0", name, bus_req, stall);
      else n_pass++;
      n_checks++;
      if (rdata !== exp_rdata) $display("[TB] FAIL %s err_rdata got %h want %h", name, rdata, exp_rdata);
      else n_pass++;
      @(posedge clk); #1;
      @(negedge clk);
      n_checks++;
      if (lsu_err !== 1'b0) $display("[TB] FAIL %s err_once got %b want 0", name, lsu_err);
      else n_pass++;
      return;
    end
    stall_cnt = 1;
    for (int n = 0; n < TIMEOUT; n++) begin
      @(posedge clk); #1;
      if (n == waits) begin bus_ready = 1'b1; bus_rdata = rword; end
      else bus_rdata = $urandom;
      @(negedge clk);
      if (stall) stall_cnt++;
      n_checks++;
      if (bus_req !== 1'b1 || bus_we !== wr || bus_addr !== (a & ~32'd3) || bus_be !== model_be(m, a) ||
          bus_wdata !== model_wdata(m, wd))
        $display("[TB] FAIL %s req_bus got req=%b we=%b addr=%h be=%b wd=%h want 1 %b %h %b %h", name, bus_req,
                 bus_we, bus_addr, bus_be, bus_wdata, wr, a & ~32'd3, model_be(m, a), model_wdata(m, wd));
      else n_pass++;
      if (n == waits) break;
    end
    @(posedge clk); #1;
    bus_ready = 1'b0; rd_en = 1'b0; wr_en = 1'b0;
    if (!wr) exp_rdata = tout ? 32'd0 : model_load(m, a, rword);
    @(negedge clk);
    n_checks++;
    if (stall !== 1'b0 || bus_req !== 1'b0) $display("[TB] FAIL %s done_idle got stall=%b req=%b want 0 0", name, stall, bus_req);
    else n_pass++;
    n_checks++;
    if (rdata !== exp_rdata) $display("[TB] FAIL %s done_rdata got %h want %h", name, rdata, exp_rdata);
    else n_pass++;
    n_checks++;
    if (lsu_err !== tout) $display("[TB] FAIL %s done_err got %b want %b", name, lsu_err, tout);
    else n_pass++;
    n_checks++;
    if (stall_cnt != (tout ? TIMEOUT + 1 : waits + 2)) $display("[TB] FAIL %s stall_cycles got %0d want %0d", name, stall_cnt, tout ? TIMEOUT + 1 : waits + 2);
    else n_pass++;
    @(posedge clk); #1;
    @(negedge clk);
    n_checks++;
    if (lsu_err !== 1'b0 || bus_req !== 1'b0) $display("[TB] FAIL %s after_done got err=%b req=%b want 0 0", name, lsu_err, bus_req);
    else n_pass++;
  endtask

  task automatic test_reset();
    rst = 1'b1; rd_en = 1'b0; wr_en = 1'b0; mem_acc_mode = 3'd7; addr = 32'd0; wdata = 32'd0;
    bus_ready = 1'b0; bus_rdata = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    n_checks++;
    if (rdata !== 32'd0 || lsu_err !== 1'b0 || bus_req !== 1'b0 || bus_we !== 1'b0 || bus_addr !== 32'd0 ||
        bus_be !== 4'd0 || bus_wdata !== 32'd0 || stall !== 1'b0)
      $display("[TB] FAIL reset_state got rdata=%h err=%b req=%b we=%b addr=%h be=%b wd=%h stall=%b want all 0",
               rdata, lsu_err, bus_req, bus_we, bus_addr, bus_be, bus_wdata, stall);
    else n_pass++;
    @(posedge clk); #1;
    rst = 1'b0;
    exp_rdata = 32'd0;
  endtask

  task automatic test_directed();
    run_access(1, 0, 3'b010, 32'h0000_0104, 32'h0, 0, 32'hDEAD_BEEF, "word_load");
    run_access(1, 0, 3'b000, 32'h0000_2003, 32'h0, 0, 32'h8011_2233, "sbyte_load");
    run_access(1, 0, 3'b011, 32'h0000_2003, 32'h0, 0, 32'h8011_2233, "ubyte_load");
    run_access(0, 1, 3'b001, 32'h0000_3002, 32'h0000_ABCD, 3, 32'h0, "half_store");
    run_access(1, 0, 3'b010, 32'h0000_3006, 32'h0, 0, 32'h0, "misaligned_word");
    run_access(0, 1, 3'b100, 32'h0000_3004, 32'h1234, 0, 32'h0, "store_mode100");
    run_access(1, 1, 3'b010, 32'h0000_3004, 32'h1234, 0, 32'h0, "rd_and_wr");
    run_access(1, 0, 3'b001, 32'h0000_3006, 32'h0, 1, 32'hF00D_8001, "shalf_load_hi");
  endtask

  task automatic test_timeout();
    run_access(1, 0, 3'b010, 32'h0000_4000, 32'h0, TIMEOUT, 32'h0, "timeout_load");
    run_access(1, 0, 3'b010, 32'h0000_4004, 32'h0, TIMEOUT - 1, 32'h5A5A_1234, "ready_last_cycle");
  endtask

  task automatic test_reset_mid_req();
    @(posedge clk); #1;
    rd_en = 1'b1; wr_en = 1'b0; mem_acc_mode = 3'b010; addr = 32'h0000_0200; bus_ready = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1; rd_en = 1'b0;
    @(negedge clk);
    n_checks++;
    if (bus_req !== 1'b1) $display("[TB] FAIL rst_mid_before got req=%b want 1", bus_req);
    else n_pass++;
    @(posedge clk); #1;
    rst = 1'b0;
    exp_rdata = 32'd0;
    @(negedge clk);
    n_checks++;
    if (bus_req !== 1'b0 || stall !== 1'b0 || rdata !== 32'd0)
      $display("[TB] FAIL rst_mid_after got req=%b stall=%b rdata=%h want 0 0 0", bus_req, stall, rdata);
    else n_pass++;
  endtask

  task automatic test_ready_idle();
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      bus_ready = 1'b1; bus_rdata = $urandom;
      @(negedge clk);
      n_checks++;
      if (bus_req !== 1'b0 || stall !== 1'b0 || rdata !== exp_rdata)
        $display("[TB] FAIL ready_idle got req=%b stall=%b rdata=%h want 0 0 %h", bus_req, stall, rdata, exp_rdata);
      else n_pass++;
    end
    @(posedge clk); #1;
    bus_ready = 1'b0;
  endtask

  task automatic test_random();
    for (int i = 0; i < 60; i++) begin
      int sel = $urandom_range(0, 9);
      logic rd = (sel < 5) || (sel == 9);
      logic wr = (sel >= 5);
      logic [2:0] m = 3'($urandom_range(0, 7));
      logic [31:0] a = $urandom;
      int waits = ($urandom_range(0, 15) == 0) ? TIMEOUT : $urandom_range(0, 3);
      if (sel == 8 && $urandom_range(0, 1) == 0) begin rd = 1'b0; wr = 1'b0; end
      if ($urandom_range(0, 2) != 0) a[1:0] = 2'b00;
      run_access(rd, wr, m, a, $urandom, waits, $urandom, "random");
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_timeout();
    test_reset_mid_req();
    test_ready_idle();
    test_directed();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
